btb_update_ctrl: RTL and testbench
==================================

Name: btb_update_ctrl

Overview:
Write-side controller for the branch predictor's direct-mapped target table: 2048 entries of 18 bits each, organised as {valid, state[1:0], tag[1:0], target[12:0]}. After reset or a flush request it sequences a full-table clear. In normal running it turns each branch resolved in the E stage into a single write with a 2-bit saturating-counter update. It drives the table's w_addr/w_data/wen and a ready flag that the fetch stage ANDs with hit_predict.

Parameters:
PC_W, 13, word-address PC width (byte PC bits [14:2])
IDX_W, 11, table index width, taken from pc[10:0]
TAG_W, 2, tag width, taken from pc[12:11]
CTR_W, 16, width of the statistics counters

Ports:
CLK  in  1  clock; all state updates on posedge
RSTN  in  1  asynchronous active-low reset
flush_req  in  1  one-cycle pulse; re-clear the whole table
upd_valid  in  1  a conditional branch resolved in E this cycle
upd_pc  in  13  PC of the resolved branch
upd_taken  in  1  actual branch outcome
upd_target  in  13  actual taken target
upd_hit  in  1  hit_predict captured at F and piped with the instruction
upd_state  in  2  state read at F, piped
upd_prepc  in  13  prepc read at F, piped
w_addr  out  11  table write index (registered)
w_data  out  18  table write data (registered)
wen  out  1  table write enable (registered)
ready  out  1  1 when in RUN; predictions are trusted only when ready=1
stat_upd  out  16  count of writes issued in RUN (wraps)
stat_drop  out  16  count of updates dropped (wraps)

Behaviour:
- Reset (RSTN=0, asynchronous):
  - wen=0, w_addr=0, w_data=0, ready=0, stat_upd=0, stat_drop=0.
  - FSM=CLEAR, clear counter clr_idx=0.
- FSM states: CLEAR and RUN.
- CLEAR:
  - Each cycle, register wen=1, w_addr=clr_idx, w_data=0, then increment clr_idx.
  - When clr_idx=2047 is written, go to RUN next cycle. This gives exactly 2048 consecutive writes, addresses 0..2047.
  - ready=0 throughout CLEAR.
  - upd_valid in CLEAR: the update is discarded and stat_drop increments.
  - flush_req in CLEAR: clr_idx restarts at 0 next cycle.
- RUN:
  - ready=1.
  - flush_req=1 sends the FSM to CLEAR with clr_idx=0. If upd_valid is also 1 in that cycle, flush wins, the update is dropped and stat_drop increments.
- Update rules in RUN. Outputs are registered one cycle after upd_valid; latency is 1 and throughput is 1 update per cycle.
  - idx = upd_pc[10:0], tag = upd_pc[12:11].
  - Hit: ns = upd_taken ? min(upd_state+1, 3) : max(upd_state-1, 0).
    - New target = upd_taken ? upd_target : upd_prepc.
    - Write {1, ns, tag, target}.
    - Suppress the write (wen=0, stat_upd unchanged) when ns==upd_state and the new target equals upd_prepc.
  - Miss and taken: allocate {1, 2'b10, tag, upd_target}. This overwrites any entry with a different tag.
  - Miss and not taken: no write.
  - Each issued write increments stat_upd.
- State encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken. The fetch stage predicts taken when state[1]=1.
- Cycles with no write: wen=0; w_addr and w_data hold their last values.
- Counters: wrap modulo 2^16 with no saturation.
- Reset asserted mid-CLEAR or mid-RUN: immediate return to reset values; the clear sequence restarts from 0 after release.

Decomposition:
- Shared package: BTB entry field offsets (VALID_BIT=17, STATE_MSB=16, TAG_MSB=14, TGT_MSB=12), state constants (SNT, WNT, WT, ST), and the FSM state encoding (CLEAR, RUN).
- One natural sub-module, btb_sat_ctr: combinational 2-bit saturating increment/decrement, reused by the predictor's verification model.

Test Plan:
- Reset release, idle inputs -> wen=1 for 2048 consecutive cycles, w_addr 0..2047, w_data=0; ready rises on cycle 2049; no writes afterwards.
- RUN, upd_valid, pc=0x1234, taken=1, target=0x0ABC, hit=0 -> next cycle wen=1, w_addr=0x234, w_data={1,2'b10,2'b10,13'h0ABC}; stat_upd=1.
- RUN, hit=1, state=10, taken=0, prepc=0x0ABC -> w_data={1,2'b01,tag,0x0ABC}. A following hit with state=00, taken=0, prepc unchanged -> wen=0 and stat_upd unchanged.
- RUN, hit=1, state=11, taken=1, target=prepc -> no write. Same case with target!=prepc -> write with state 11 and the new target.
- flush_req together with upd_valid in RUN -> ready=0 next cycle, update dropped (stat_drop=1), clear restarts at address 0. An upd_valid during the clear -> stat_drop=2 and no update write.
- RSTN pulsed low at clear index 1000 -> outputs zero immediately; after release the clear restarts at address 0 and completes all 2048 writes.

Source files
------------

// File: rtl/btb_update_ctrl_pkg.sv
// btb_update_ctrl_pkg: shared widths, entry layout, counter states and FSM encoding
package btb_update_ctrl_pkg;
  localparam int PC_W      = 13;
  localparam int IDX_W     = 11;
  localparam int TAG_W     = 2;
  localparam int CTR_W     = 16;
  localparam int VALID_BIT = 17;
  localparam int STATE_MSB = 16;
  localparam int TAG_MSB   = 14;
  localparam int TGT_MSB   = 12;
  localparam int ENT_W     = VALID_BIT + 1;
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;
  typedef enum logic {CLEAR, RUN} fsm_e;
endpackage

// File: rtl/btb_sat_ctr.sv
// btb_sat_ctr: combinational 2-bit saturating increment/decrement
module btb_sat_ctr
  import btb_update_ctrl_pkg::*;
(
  input  logic [1:0] s_i,
  input  logic       inc_i,
  output logic [1:0] ns_o
);
  assign ns_o = inc_i ? (s_i == ST ? ST : s_i + 2'd1) : (s_i == SNT ? SNT : s_i - 2'd1);
endmodule

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: table clear sequencer and resolved-branch write controller for the BTB
module btb_update_ctrl
  import btb_update_ctrl_pkg::*;
(
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             flush_req,
  input  logic             upd_valid,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic [PC_W-1:0]  upd_target,
  input  logic             upd_hit,
  input  logic [1:0]       upd_state,
  input  logic [PC_W-1:0]  upd_prepc,
  output logic [IDX_W-1:0] w_addr,
  output logic [ENT_W-1:0] w_data,
  output logic             wen,
  output logic             ready,
  output logic [CTR_W-1:0] stat_upd,
  output logic [CTR_W-1:0] stat_drop
);
  fsm_e             state_q, state_d;
  logic [IDX_W-1:0] clr_q, clr_d, addr_q, addr_d;
  logic [ENT_W-1:0] data_q, data_d;
  logic             wen_q, wen_d, ready_q, ready_d;
  logic [CTR_W-1:0] upd_q, upd_d, drop_q, drop_d;
  logic [1:0]       ns;
  logic [PC_W-1:0]  tgt;
  logic             do_wr;

  btb_sat_ctr u_ctr (.s_i(upd_state), .inc_i(upd_taken), .ns_o(ns));

  assign tgt   = upd_taken ? upd_target : upd_prepc;
  assign do_wr = upd_hit ? !(ns == upd_state && tgt == upd_prepc) : upd_taken;

  // next state: clear sweep, flush handling, and update write formation
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wen_d   = 1'b0;
    upd_d   = upd_q;
    drop_d  = drop_q;
    ready_d = state_q == RUN && !flush_req;
    if (state_q == CLEAR) begin
      wen_d  = 1'b1;
      addr_d = clr_q;
      data_d = '0;
      clr_d  = flush_req ? '0 : clr_q + IDX_W'(1);
      if (clr_q == '1 && !flush_req) state_d = RUN;
      if (upd_valid) drop_d = drop_q + CTR_W'(1);
    end else if (flush_req) begin
      state_d = CLEAR;
      clr_d   = '0;
      if (upd_valid) drop_d = drop_q + CTR_W'(1);
    end else if (upd_valid && do_wr) begin
      wen_d  = 1'b1;
      addr_d = upd_pc[IDX_W-1:0];
      data_d = {1'b1, upd_hit ? ns : WT, upd_pc[PC_W-1:IDX_W], tgt};
      upd_d  = upd_q + CTR_W'(1);
    end
  end

  // registered state and table write port
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      state_q <= CLEAR;
      clr_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wen_q   <= 1'b0;
      ready_q <= 1'b0;
      upd_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wen_q   <= wen_d;
      ready_q <= ready_d;
      upd_q   <= upd_d;
      drop_q  <= drop_d;
    end

  assign w_addr    = addr_q;
  assign w_data    = data_q;
  assign wen       = wen_q;
  assign ready     = ready_q;
  assign stat_upd  = upd_q;
  assign stat_drop = drop_q;
endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb_btb_update_ctrl: table-driven and scoreboard checks of the BTB write controller
module tb_btb_update_ctrl;
  logic        CLK, RSTN, flush_req, upd_valid, upd_taken, upd_hit;
  logic [12:0] upd_pc, upd_target, upd_prepc;
  logic [1:0]  upd_state;
  logic [10:0] w_addr;
  logic [17:0] w_data;
  logic        wen, ready;
  logic [15:0] stat_upd, stat_drop;

  btb_update_ctrl dut (
    .CLK(CLK), .RSTN(RSTN), .flush_req(flush_req), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_hit(upd_hit), .upd_state(upd_state), .upd_prepc(upd_prepc),
    .w_addr(w_addr), .w_data(w_data), .wen(wen), .ready(ready),
    .stat_upd(stat_upd), .stat_drop(stat_drop)
  );

  typedef struct {
    logic        hit;
    logic [1:0]  state;
    logic        taken;
    logic [12:0] pc;
    logic [12:0] target;
    logic [12:0] prepc;
    logic        ewen;
    logic [17:0] edata;
  } vec_t;

  typedef struct {
    logic        wen;
    logic [10:0] addr;
    logic [17:0] data;
    logic [15:0] upd;
    logic [15:0] drop;
  } exp_t;

  vec_t        vt[10];
  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  logic [10:0] m_addr;
  logic [17:0] m_data;
  logic [15:0] m_upd, m_drop;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    flush_req = 0; upd_valid = 0; upd_pc = 0; upd_taken = 0;
    upd_target = 0; upd_hit = 0; upd_state = 0; upd_prepc = 0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_zero(input string name);
    chk({name, "_wen"}, wen, 0);
    chk({name, "_addr"}, w_addr, 0);
    chk({name, "_data"}, w_data, 0);
    chk({name, "_ready"}, ready, 0);
    chk({name, "_upd"}, stat_upd, 0);
    chk({name, "_drop"}, stat_drop, 0);
  endtask

  task automatic check_clear(input string name);
    int bad = 0;
    for (int i = 0; i < 2048; i++) begin
      step();
      if (!(wen === 1'b1 && w_addr === 11'(i) && w_data === 18'h0 && ready === 1'b0)) bad++;
    end
    chk({name, "_seq_bad_cycles"}, bad, 0);
    step();
    chk({name, "_done_wen"}, wen, 0);
    chk({name, "_done_ready"}, ready, 1);
    chk({name, "_done_addr"}, w_addr, 11'h7FF);
    step();
    chk({name, "_idle_wen"}, wen, 0);
    m_addr = 11'h7FF;
    m_data = 18'h0;
  endtask

  task automatic drive_vec(input vec_t v);
    exp_t e;
    upd_valid = 1; flush_req = 0; upd_hit = v.hit; upd_state = v.state;
    upd_taken = v.taken; upd_pc = v.pc; upd_target = v.target; upd_prepc = v.prepc;
    if (v.ewen) begin
      m_addr = v.pc[10:0];
      m_data = v.edata;
      m_upd  = m_upd + 16'd1;
    end
    e.wen = v.ewen; e.addr = m_addr; e.data = m_data; e.upd = m_upd; e.drop = m_drop;
    sbq.push_back(e);
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({name, "_sb_empty"}, 1, 0);
      return;
    end
    e = sbq.pop_front();
    chk({name, "_wen"}, wen, e.wen);
    chk({name, "_addr"}, w_addr, e.addr);
    chk({name, "_data"}, w_data, e.data);
    chk({name, "_upd"}, stat_upd, e.upd);
    chk({name, "_drop"}, stat_drop, e.drop);
  endtask

  initial begin
    vt[0] = '{1'b0, 2'b00, 1'b1, 13'h1234, 13'h0ABC, 13'h0000, 1'b1, 18'h34ABC};
    vt[1] = '{1'b1, 2'b10, 1'b0, 13'h1234, 13'h0000, 13'h0ABC, 1'b1, 18'h2CABC};
    vt[2] = '{1'b1, 2'b00, 1'b0, 13'h1234, 13'h0000, 13'h0ABC, 1'b0, 18'h0};
    vt[3] = '{1'b1, 2'b11, 1'b1, 13'h0456, 13'h0155, 13'h0155, 1'b0, 18'h0};
    vt[4] = '{1'b1, 2'b11, 1'b1, 13'h0456, 13'h1FFF, 13'h0155, 1'b1, 18'h39FFF};
    vt[5] = '{1'b0, 2'b11, 1'b0, 13'h1FFF, 13'h0123, 13'h0456, 1'b0, 18'h0};
    vt[6] = '{1'b1, 2'b01, 1'b1, 13'h0FFF, 13'h0777, 13'h0000, 1'b1, 18'h32777};
    vt[7] = '{1'b1, 2'b00, 1'b1, 13'h1800, 13'h0100, 13'h0100, 1'b1, 18'h2E100};
    vt[8] = '{1'b1, 2'b01, 1'b0, 13'h0001, 13'h0000, 13'h1555, 1'b1, 18'h21555};
    vt[9] = '{1'b1, 2'b11, 1'b0, 13'h0002, 13'h1111, 13'h0AAA, 1'b1, 18'h30AAA};
    m_upd = 0; m_drop = 0; m_addr = 0; m_data = 0;

    idle();
    RSTN = 0;
    #3;
    check_zero("reset");
    @(negedge CLK);
    @(negedge CLK);
    RSTN = 1;
    check_clear("clear0");
    chk("clear0_upd", stat_upd, 0);

    for (int i = 0; i < 10; i++) begin
      drive_vec(vt[i]);
      step();
      pop_check($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_ready", i), ready, 1);
    end
    idle();
    step();
    chk("idle_wen", wen, 0);
    chk("idle_addr_hold", w_addr, m_addr);
    chk("idle_data_hold", w_data, m_data);

    flush_req = 1; upd_valid = 1; upd_hit = 0; upd_taken = 1;
    upd_pc = 13'h0333; upd_target = 13'h0444;
    m_drop = m_drop + 16'd1;
    step();
    chk("flush_ready", ready, 0);
    chk("flush_wen", wen, 0);
    chk("flush_drop", stat_drop, m_drop);
    chk("flush_upd", stat_upd, m_upd);
    flush_req = 0;
    m_drop = m_drop + 16'd1;
    step();
    chk("clr_upd_wen", wen, 1);
    chk("clr_upd_addr", w_addr, 0);
    chk("clr_upd_data", w_data, 0);
    chk("clr_upd_drop", stat_drop, 16'd2);
    chk("clr_upd_upd", stat_upd, m_upd);
    idle();
    repeat (1000) step();
    chk("clr_at1000_addr", w_addr, 11'd1000);
    chk("clr_at1000_wen", wen, 1);

    RSTN = 0;
    #1;
    check_zero("midrst");
    m_upd = 0; m_drop = 0;
    @(negedge CLK);
    RSTN = 1;
    check_clear("clear1");

    drive_vec(vt[0]);
    step();
    pop_check("post_rst");
    idle();
    step();
    chk("post_rst_idle_wen", wen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
